alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 129 ++++++++++++
 tb/tb_alu_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester ALU front end: grants one operation at a time (round robin on ties),
// executes it in one cycle and holds the result until the consumer takes it.
module alu_arbiter #(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [1:0]           req_valid,
   output logic [1:0]           req_ready,
   input  logic [5:0]           req_op,
   input  logic [2*WIDTH-1:0]   req_a,
   input  logic [2*WIDTH-1:0]   req_b,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic                 resp_id,
   output logic [WIDTH-1:0]     resp_y,
   output logic                 resp_zero,
   output logic                 resp_carry,
   output logic [1:0]           fsm_state
);

   // Handshake: a request moves on a rising edge where req_valid[i] && req_ready[i];
   // a response moves on a rising edge where resp_valid && resp_ready.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic             last_gnt;
   logic             gnt_id;
   logic             accept;
   logic [2:0]       op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             id_q;
   logic [WIDTH-1:0] alu_y;
   logic             alu_carry;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;

   assign fsm_state = state;

   // On a tie the requester that did not win last time gets the grant.
   assign gnt_id = (&req_valid) ? ~last_gnt : req_valid[1];

   always_comb begin
      state_nxt = state;
      req_ready = 2'b00;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if ((|req_valid) && !rst) begin
               req_ready = gnt_id ? 2'b10 : 2'b01;
               accept    = 1'b1;
               state_nxt = EXEC;
            end
         end
         EXEC: state_nxt = RESP;
         RESP: begin
            if (resp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      sum       = {1'b0, a_q} + {1'b0, b_q};
      diff      = {1'b0, a_q} - {1'b0, b_q};
      alu_y     = '0;
      alu_carry = 1'b0;
      case (op_q)
         3'b000: alu_y = a_q & b_q;
         3'b001: alu_y = a_q | b_q;
         3'b010: alu_y = a_q ^ b_q;
         3'b011: alu_y = ~(a_q | b_q);
         3'b100: begin
            alu_y     = sum[WIDTH-1:0];
            alu_carry = sum[WIDTH];
         end
         3'b101: begin
            // Top bit of the widened difference is the borrow.
            alu_y     = diff[WIDTH-1:0];
            alu_carry = diff[WIDTH];
         end
         3'b110: alu_y = a_q << b_q[3:0];
         default: alu_y = a_q >> b_q[3:0];
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_gnt   <= 1'b1;
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         id_q       <= 1'b0;
         resp_valid <= 1'b0;
         resp_id    <= 1'b0;
         resp_y     <= '0;
         resp_zero  <= 1'b0;
         resp_carry <= 1'b0;
      end else begin
         if (accept) begin
            last_gnt <= gnt_id;
            id_q     <= gnt_id;
            op_q     <= gnt_id ? req_op[5:3] : req_op[2:0];
            a_q      <= gnt_id ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
            b_q      <= gnt_id ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
         end
         if (state == EXEC) begin
            resp_valid <= 1'b1;
            resp_id    <= id_q;
            resp_y     <= alu_y;
            resp_zero  <= (alu_y == '0);
            resp_carry <= alu_carry;
         end
         if ((state == RESP) && resp_ready) resp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: hand-computed vectors checked with immediate assertions.
module tb_alu_arbiter;

   logic        clk;
   logic        rst;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [5:0]  req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic        resp_valid;
   logic        resp_ready;
   logic        resp_id;
   logic [15:0] resp_y;
   logic        resp_zero;
   logic        resp_carry;
   logic [1:0]  fsm_state;

   int n_checks;
   int n_pass;

   alu_arbiter #(.WIDTH(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_id    (resp_id),
      .resp_y     (resp_y),
      .resp_zero  (resp_zero),
      .resp_carry (resp_carry),
      .fsm_state  (fsm_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic drive_req(input int id, input logic [2:0] op, input logic [15:0] a,
                            input logic [15:0] b);
      req_op = '0;
      req_a  = '0;
      req_b  = '0;
      if (id == 0) begin
         req_valid = 2'b01;
         req_op[2:0] = op;
         req_a[15:0] = a;
         req_b[15:0] = b;
      end else begin
         req_valid = 2'b10;
         req_op[5:3]  = op;
         req_a[31:16] = a;
         req_b[31:16] = b;
      end
   endtask

   // Called just after a falling edge with the FSM in IDLE and resp_ready high.
   task automatic do_op(input string tag, input int id, input logic [2:0] op,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp_y, input logic exp_zero, input logic exp_carry);
      drive_req(id, op, a, b);
      #1;
      check({tag, "_ready"}, 32'(req_ready), (id == 0) ? 32'h1 : 32'h2);
      @(negedge clk);
      req_valid = 2'b00;
      req_op    = 6'($urandom);
      req_a     = $urandom;
      req_b     = $urandom;
      #1;
      check({tag, "_exec_ready"}, 32'(req_ready), 32'h0);
      check({tag, "_exec_valid"}, 32'(resp_valid), 32'h0);
      @(negedge clk);
      #1;
      check({tag, "_valid"}, 32'(resp_valid), 32'h1);
      check({tag, "_id"},    32'(resp_id),    32'(id));
      check({tag, "_y"},     32'(resp_y),     32'(exp_y));
      check({tag, "_zero"},  32'(resp_zero),  32'(exp_zero));
      check({tag, "_carry"}, 32'(resp_carry), 32'(exp_carry));
      @(negedge clk);
      #1;
      check({tag, "_done_valid"}, 32'(resp_valid), 32'h0);
      check({tag, "_done_state"}, 32'(fsm_state),  32'h0);
   endtask

   initial begin
      n_checks   = 0;
      n_pass     = 0;
      rst        = 1'b1;
      req_valid  = 2'b00;
      req_op     = '0;
      req_a      = '0;
      req_b      = '0;
      resp_ready = 1'b1;
      repeat (2) @(negedge clk);

      // Reset state, with requests pending so req_ready gating is exercised.
      req_valid = 2'b11;
      #1;
      check("rst_ready", 32'(req_ready),  32'h0);
      check("rst_valid", 32'(resp_valid), 32'h0);
      check("rst_y",     32'(resp_y),     32'h0);
      check("rst_id",    32'(resp_id),    32'h0);
      check("rst_zero",  32'(resp_zero),  32'h0);
      check("rst_carry", 32'(resp_carry), 32'h0);
      check("rst_state", 32'(fsm_state),  32'h0);
      @(negedge clk);
      req_valid = 2'b00;
      rst       = 1'b0;

      do_op("or",      0, 3'b001, 16'h00F0, 16'h0F0F, 16'h0FFF, 1'b0, 1'b0);
      do_op("add_wrap",1, 3'b100, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1);
      do_op("sub_brw", 0, 3'b101, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b1);
      do_op("shl15",   1, 3'b110, 16'h0001, 16'h000F, 16'h8000, 1'b0, 1'b0);
      do_op("shr0",    0, 3'b111, 16'h8000, 16'h0000, 16'h8000, 1'b0, 1'b0);
      do_op("nor",     1, 3'b011, 16'h00F0, 16'h0F0F, 16'hF000, 1'b0, 1'b0);
      do_op("and",     0, 3'b000, 16'hFF00, 16'h0F0F, 16'h0F00, 1'b0, 1'b0);
      do_op("xor_z",   1, 3'b010, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0);
      do_op("sub_nb",  0, 3'b101, 16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0);

      // Backpressure: result must hold while resp_ready is low.
      resp_ready = 1'b0;
      drive_req(0, 3'b010, 16'hAAAA, 16'h5555);
      @(negedge clk);
      req_valid = 2'b11;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         #1;
         check("bp_valid", 32'(resp_valid), 32'h1);
         check("bp_y",     32'(resp_y),     32'hFFFF);
         check("bp_id",    32'(resp_id),    32'h0);
         check("bp_ready", 32'(req_ready),  32'h0);
         @(negedge clk);
      end
      resp_ready = 1'b1;
      req_valid  = 2'b00;
      @(negedge clk);
      #1;
      check("bp_rel_state", 32'(fsm_state),  32'h0);
      check("bp_rel_valid", 32'(resp_valid), 32'h0);

      // Asynchronous reset in EXEC: held result cleared at once, no response afterwards.
      drive_req(1, 3'b100, 16'h0001, 16'h0001);
      @(negedge clk);
      req_valid = 2'b11;
      req_op    = {3'b101, 3'b100};
      req_a     = {16'd5, 16'd1};
      req_b     = {16'd3, 16'd2};
      #1;
      check("mid_exec_state", 32'(fsm_state), 32'h1);
      #1;
      rst = 1'b1;
      #1;
      check("mid_rst_y",     32'(resp_y),     32'h0);
      check("mid_rst_valid", 32'(resp_valid), 32'h0);
      check("mid_rst_state", 32'(fsm_state),  32'h0);
      check("mid_rst_ready", 32'(req_ready),  32'h0);
      repeat (2) begin
         @(negedge clk);
         #1;
         check("mid_rst_noresp", 32'(resp_valid), 32'h0);
      end
      @(negedge clk);
      rst = 1'b0;

      // Contention right after reset: requester 0 wins first, then strict alternation.
      for (int k = 0; k < 4; k++) begin
         #1;
         check("rr_grant", 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
         @(negedge clk);
         #1;
         check("rr_exec_ready", 32'(req_ready), 32'h0);
         @(negedge clk);
         #1;
         check("rr_valid", 32'(resp_valid), 32'h1);
         check("rr_id",    32'(resp_id),    32'(k % 2));
         check("rr_y",     32'(resp_y),     (k % 2 == 0) ? 32'h3 : 32'h2);
         @(negedge clk);
      end
      req_valid = 2'b00;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
